mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM boundary and the write-back multiplexer. It issues loads and stores to the data memory over a request/acknowledge handshake and stalls the pipeline while an access is outstanding. It sign- or zero-extends sub-word load data and registers the MEM/WB values: ALU result, aligned load data, the load-select flag `sld`, and the destination register fields consumed by write-back.

---
 rtl/mem_access_stage.sv | 149 ++++++++++++++
 tb/tb_mem_access_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage : pipeline MEM stage issuing data-memory loads/stores   |
// |                    over req/ack and registering the MEM/WB values.       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              em_valid,
    input  logic [31:0]       em_alu,
    input  logic [31:0]       em_b,
    input  logic              em_rmem,
    input  logic              em_wmem,
    input  logic [1:0]        em_size,
    input  logic              em_unsigned,
    input  logic              em_wreg,
    input  logic [4:0]        em_rd,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              mem_stall,
    output logic              mem_misalign,
    output logic              mw_valid,
    output logic [31:0]       mw_alu,
    output logic [31:0]       mw_mem,
    output logic              mw_sld,
    output logic              mw_wreg,
    output logic [4:0]        mw_rd
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  w_off;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_go;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_off      = em_alu[1:0];
    assign w_mem_op   = em_valid & (em_rmem | em_wmem);
    assign w_misalign = ((em_size == 2'b01) & w_off[0]) | (em_size[1] & (w_off != 2'b00));
    assign w_go       = w_mem_op & ~w_misalign;
    assign mem_stall  = w_go & ~((r_state == S_WAIT) & dm_ack);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = em_b;
        case (em_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{em_b[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{em_b[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select is little-endian: byte offset 0 lives in dm_rdata[7:0].
    assign w_byte = dm_rdata[8*w_off +: 8];
    assign w_half = w_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        case (em_size)
            2'b00:   w_load = {{24{~em_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~em_unsigned & w_half[15]}}, w_half};
            default: w_load = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            dm_req       <= 1'b0;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_be        <= 4'b0000;
            dm_wdata     <= 32'h0;
            mem_misalign <= 1'b0;
            mw_valid     <= 1'b0;
            mw_alu       <= 32'h0;
            mw_mem       <= 32'h0;
            mw_sld       <= 1'b0;
            mw_wreg      <= 1'b0;
            mw_rd        <= 5'h0;
        end else begin
            mem_misalign <= 1'b0;
            // Bubble by default; the branches below override it.
            mw_valid     <= 1'b0;
            mw_alu       <= 32'h0;
            mw_mem       <= 32'h0;
            mw_sld       <= 1'b0;
            mw_wreg      <= 1'b0;
            mw_rd        <= 5'h0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state  <= S_WAIT;
                        dm_req   <= 1'b1;
                        dm_we    <= em_wmem;
                        dm_addr  <= {em_alu[ADDR_W-1:2], 2'b00};
                        dm_be    <= w_be;
                        dm_wdata <= w_wdata;
                    end else if (w_mem_op) begin
                        mem_misalign <= 1'b1;
                        mw_alu       <= em_alu;
                        mw_rd        <= em_rd;
                    end else begin
                        mw_valid <= em_valid;
                        mw_alu   <= em_alu;
                        mw_wreg  <= em_wreg;
                        mw_rd    <= em_rd;
                    end
                end
                default: begin
                    if (dm_ack) begin
                        r_state  <= S_IDLE;
                        dm_req   <= 1'b0;
                        mw_valid <= 1'b1;
                        mw_alu   <= em_alu;
                        mw_rd    <= em_rd;
                        if (!dm_we) begin
                            mw_mem  <= w_load;
                            mw_sld  <= 1'b1;
                            mw_wreg <= em_wreg;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_stage : randomized self-checking bench for the MEM stage   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        em_valid, em_rmem, em_wmem, em_unsigned, em_wreg;
    logic [31:0] em_alu, em_b;
    logic [1:0]  em_size;
    logic [4:0]  em_rd;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_stall, mem_misalign;
    logic        mw_valid, mw_sld, mw_wreg;
    logic [31:0] mw_alu, mw_mem;
    logic [4:0]  mw_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .em_valid(em_valid), .em_alu(em_alu), .em_b(em_b),
        .em_rmem(em_rmem), .em_wmem(em_wmem), .em_size(em_size),
        .em_unsigned(em_unsigned), .em_wreg(em_wreg), .em_rd(em_rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_stall(mem_stall), .mem_misalign(mem_misalign),
        .mw_valid(mw_valid), .mw_alu(mw_alu), .mw_mem(mw_mem),
        .mw_sld(mw_sld), .mw_wreg(mw_wreg), .mw_rd(mw_rd)
    );

    // Reference model: access width in bytes and the derived memory view.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] size, input int off);
        int mask;
        mask = (1 << nbytes(size)) - 1;
        return 4'(mask << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] b);
        logic [31:0] r;
        if (nbytes(size) == 1)      r = b[7:0] * 32'h0101_0101;
        else if (nbytes(size) == 2) r = b[15:0] * 32'h0001_0001;
        else                        r = b;
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic uns, input int off);
        longint v, m;
        v = longint'({32'h0, rdata}) >> (8 * off);
        m = longint'(1) << (8 * nbytes(size));
        v = v % m;
        if (!uns && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        em_valid = 0; em_rmem = 0; em_wmem = 0; em_size = 0; em_unsigned = 0;
        em_wreg = 0; em_rd = 0; em_alu = 0; em_b = 0; dm_ack = 0; dm_rdata = 0;
    endtask

    // Runs one aligned access with the ack arriving `lat` cycles after issue.
    task automatic do_mem_op(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] b,
                             input logic [31:0] rdata, input logic wreg,
                             input logic [4:0] rd, input int lat);
        logic [31:0] e_addr, e_wdata, e_mem;
        logic [3:0]  e_be;
        int off;
        off = int'(addr[1:0]);
        e_addr = addr & 32'hFFFF_FFFC;
        e_be = exp_be(size, off);
        e_wdata = exp_wdata(size, b);
        e_mem = exp_load(rdata, size, uns, off);
        em_valid = 1; em_alu = addr; em_b = b; em_wmem = we;
        em_rmem = we ? 1'($urandom % 2) : 1'b1;
        em_size = size; em_unsigned = uns; em_wreg = wreg; em_rd = rd;
        dm_ack = 0; dm_rdata = $urandom;
        #1;
        checks++;
        if (mem_stall !== 1'b1 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL issue_cycle: stall=%b req=%b, expected stall=1 req=0", mem_stall, dm_req);
        end
        for (int c = 1; c <= lat; c++) begin
            step();
            checks++;
            if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata} !== {1'b1, we, e_addr, e_be, e_wdata}) begin
                errors++;
                $display("FAIL request cyc%0d: req=%b we=%b addr=%h be=%b wdata=%h, expected req=1 we=%b addr=%h be=%b wdata=%h",
                         c, dm_req, dm_we, dm_addr, dm_be, dm_wdata, we, e_addr, e_be, e_wdata);
            end
            checks++;
            if (mw_valid !== 1'b0 || mw_wreg !== 1'b0) begin
                errors++;
                $display("FAIL bubble cyc%0d: mw_valid=%b mw_wreg=%b, expected 0 0", c, mw_valid, mw_wreg);
            end
            if (c == lat) begin
                dm_ack = 1; dm_rdata = rdata;
            end
            #1;
            checks++;
            if (mem_stall !== (c != lat)) begin
                errors++;
                $display("FAIL stall cyc%0d: got %b, expected %b", c, mem_stall, c != lat);
            end
        end
        step();
        checks++;
        if ({dm_req, mw_valid, mw_alu, mw_rd, mw_sld} !== {1'b0, 1'b1, addr, rd, ~we}) begin
            errors++;
            $display("FAIL complete: req=%b valid=%b alu=%h rd=%0d sld=%b, expected req=0 valid=1 alu=%h rd=%0d sld=%b",
                     dm_req, mw_valid, mw_alu, mw_rd, mw_sld, addr, rd, ~we);
        end
        checks++;
        if (mw_wreg !== (we ? 1'b0 : wreg) || mw_mem !== (we ? 32'h0 : e_mem)) begin
            errors++;
            $display("FAIL result: wreg=%b mem=%h, expected wreg=%b mem=%h",
                     mw_wreg, mw_mem, we ? 1'b0 : wreg, we ? 32'h0 : e_mem);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        step();
        step();
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, mem_stall, mem_misalign, mw_valid,
             mw_alu, mw_mem, mw_sld, mw_wreg, mw_rd} !== '0) begin
            errors++;
            $display("FAIL reset_values: req=%b addr=%h be=%b mw_valid=%b mw_alu=%h mw_mem=%h, expected all 0",
                     dm_req, dm_addr, dm_be, mw_valid, mw_alu, mw_mem);
        end
        rst = 0;
        step();
    endtask

    task automatic test_pass_through();
        logic v, w;
        logic [31:0] a;
        logic [4:0] rd;
        em_valid = 1; em_alu = 32'h1234_5678; em_wreg = 1; em_rd = 5;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: got %b, expected 0", mem_stall);
        end
        step();
        checks++;
        if ({mw_valid, mw_alu, mw_sld, mw_rd, mw_wreg} !== {1'b1, 32'h1234_5678, 1'b0, 5'd5, 1'b1}) begin
            errors++;
            $display("FAIL alu_op: valid=%b alu=%h sld=%b rd=%0d wreg=%b, expected 1 12345678 0 5 1",
                     mw_valid, mw_alu, mw_sld, mw_rd, mw_wreg);
        end
        for (int i = 0; i < 12; i++) begin
            v = 1'($urandom % 2); w = 1'($urandom % 2); a = $urandom; rd = 5'($urandom);
            em_valid = v; em_alu = a; em_wreg = w; em_rd = rd;
            em_rmem = v ? 1'b0 : 1'($urandom % 2);
            em_wmem = v ? 1'b0 : 1'($urandom % 2);
            dm_ack = 1'($urandom % 2);
            #1;
            checks++;
            if (mem_stall !== 1'b0) begin
                errors++;
                $display("FAIL pass_stall[%0d]: got %b, expected 0", i, mem_stall);
            end
            step();
            checks++;
            if (mw_valid !== v || mw_sld !== 1'b0 || dm_req !== 1'b0 ||
                (v && (mw_alu !== a || mw_wreg !== w || mw_rd !== rd || mw_mem !== 32'h0))) begin
                errors++;
                $display("FAIL pass[%0d]: valid=%b sld=%b req=%b alu=%h wreg=%b rd=%0d, expected valid=%b sld=0 req=0 alu=%h wreg=%b rd=%0d",
                         i, mw_valid, mw_sld, dm_req, mw_alu, mw_wreg, mw_rd, v, a, w, rd);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_loads_fixed();
        do_mem_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 1'b1, 5'd7, 3);
        checks++;
        if (mw_mem !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL signed_byte: mw_mem=%h, expected ffffff80", mw_mem);
        end
        step();
        do_mem_op(1'b0, 2'd1, 1'b1, 32'h2, 32'h0, 32'hBEEF_1234, 1'b1, 5'd9, 1);
        checks++;
        if (mw_mem !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL unsigned_half: mw_mem=%h, expected 0000beef", mw_mem);
        end
        step();
    endtask

    task automatic test_store_byte();
        do_mem_op(1'b1, 2'd0, 1'b0, 32'h41, 32'hAABB_CC5A, 32'h0, 1'b1, 5'd3, 2);
        checks++;
        if (mw_wreg !== 1'b0 || mw_valid !== 1'b1) begin
            errors++;
            $display("FAIL store_byte: wreg=%b valid=%b, expected 0 1", mw_wreg, mw_valid);
        end
        step();
    endtask

    task automatic misaligned_op(input logic [1:0] size, input logic [31:0] addr);
        em_valid = 1; em_rmem = 1; em_wmem = 1'($urandom % 2); em_size = size;
        em_alu = addr; em_wreg = 1; em_rd = 5'd11;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL misalign_stall: got %b, expected 0", mem_stall);
        end
        step();
        checks++;
        if ({mem_misalign, mw_valid, mw_wreg, dm_req} !== 4'b1000) begin
            errors++;
            $display("FAIL misalign: flag=%b valid=%b wreg=%b req=%b, expected 1 0 0 0",
                     mem_misalign, mw_valid, mw_wreg, dm_req);
        end
        idle_inputs();
        step();
        checks++;
        if (mem_misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: flag=%b, expected 0", mem_misalign);
        end
    endtask

    task automatic test_misaligned();
        misaligned_op(2'd2, 32'h6);
        do_mem_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'hCAFE_F00D, 1'b1, 5'd2, 1);
        step();
        misaligned_op(2'd1, 32'h0000_0103);
        misaligned_op(2'd3, 32'h0000_0201);
    endtask

    task automatic test_back_to_back();
        do_mem_op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h1111_2222, 1'b1, 5'd4, 1);
        do_mem_op(1'b1, 2'd1, 1'b0, 32'h52, 32'h0000_9876, 32'h0, 1'b0, 5'd0, 2);
        do_mem_op(1'b0, 2'd0, 1'b1, 32'h61, 32'h0, 32'h0000_F700, 1'b1, 5'd6, 1);
        step();
    endtask

    task automatic test_random_mem();
        logic [1:0] size;
        logic [31:0] addr;
        int off;
        for (int i = 0; i < 40; i++) begin
            size = 2'($urandom % 4);
            off = (size == 2'd0) ? int'($urandom % 4) : (size == 2'd1) ? 2 * int'($urandom % 2) : 0;
            addr = ($urandom & 32'hFFFF_FFFC) + 32'(off);
            do_mem_op(1'($urandom % 2), size, 1'($urandom % 2), addr, $urandom, $urandom,
                      1'($urandom % 2), 5'($urandom), int'($urandom_range(1, 4)));
            if ($urandom % 2 == 1) step();
        end
    endtask

    task automatic test_reset_wait();
        em_valid = 1; em_rmem = 1; em_wmem = 0; em_size = 2; em_alu = 32'h80; em_wreg = 1; em_rd = 8;
        step();
        checks++;
        if (dm_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_setup: req=%b, expected 1", dm_req);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({dm_req, dm_we, dm_addr, mw_valid, mw_alu, mw_mem, mw_sld, mw_wreg, mw_rd} !== '0) begin
            errors++;
            $display("FAIL rst_async: req=%b addr=%h mw_valid=%b mw_wreg=%b, expected all 0",
                     dm_req, dm_addr, mw_valid, mw_wreg);
        end
        step();
        rst = 0;
        idle_inputs();
        dm_ack = 1; dm_rdata = 32'h1234_5678;
        step();
        dm_ack = 0;
        checks++;
        if (mw_valid !== 1'b0 || mw_sld !== 1'b0 || dm_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: mw_valid=%b sld=%b req=%b, expected 0 0 0", mw_valid, mw_sld, dm_req);
        end
        do_mem_op(1'b0, 2'd2, 1'b0, 32'h90, 32'h0, 32'h0BAD_F00D, 1'b1, 5'd12, 2);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass_through();
        test_loads_fixed();
        test_store_byte();
        test_misaligned();
        test_back_to_back();
        test_random_mem();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
